// File: rtl/mesh_seq_pkg.sv
// mesh_seq_pkg: shared widths and FSM encoding for the mesh tile sequencer.
package mesh_seq_pkg;
  localparam int DIM_DEF = 8;
  localparam int SHIFT_W = 5;
  localparam int CNT_W = 8;
  localparam int ROW_W = 2 + SHIFT_W;
  typedef enum logic [2:0] {IDLE, PRELOAD, COMPUTE, DRAIN, DONE} state_t;
endpackage

// File: rtl/mesh_seq_ctrl_if.sv
// mesh_seq_ctrl_if: command, operand, mesh-control, result and status signals of the sequencer.
interface mesh_seq_ctrl_if
  import mesh_seq_pkg::*;
#(
  parameter int DIM = DIM_DEF
);
  logic cmd_valid, cmd_ready, cmd_preload;
  logic [CNT_W-1:0] cmd_rows;
  logic [SHIFT_W-1:0] cmd_shift;
  logic in_valid, in_ready;
  logic [DIM-1:0] mesh_valid, mesh_propagate;
  logic [SHIFT_W*DIM-1:0] mesh_shift;
  logic mesh_out_valid, res_valid, res_last, busy, done, err;
  modport master (
    output cmd_valid, cmd_rows, cmd_preload, cmd_shift, in_valid, mesh_out_valid,
    input cmd_ready, in_ready, mesh_valid, mesh_propagate, mesh_shift, res_valid, res_last, busy, done, err
  );
  modport slave (
    input cmd_valid, cmd_rows, cmd_preload, cmd_shift, in_valid, mesh_out_valid,
    output cmd_ready, in_ready, mesh_valid, mesh_propagate, mesh_shift, res_valid, res_last, busy, done, err
  );
endinterface

// File: rtl/mesh_skew_line.sv
// mesh_skew_line: diagonal skew; row i receives the registered row-0 word delayed by i more cycles.
module mesh_skew_line #(
  parameter int DIM = 8,
  parameter int W = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic [W-1:0] word,
  output logic [DIM*W-1:0] line
);
  logic [DIM-1:0][W-1:0] stage;
  always_ff @(posedge clk or posedge rst)
    if (rst) stage <= '0;
    else begin
      stage[0] <= word;
      for (int i = 1; i < DIM; i++) stage[i] <= stage[i-1];
    end
  assign line = stage;
endmodule

// File: rtl/mesh_seq_ctrl.sv
// mesh_seq_ctrl: PRELOAD/COMPUTE/DRAIN tile sequencer for a DIM x DIM systolic mesh.
// Defining MESH_SEQ_TIMEOUT_EN adds a DRAIN watchdog that sets sticky err after DRAIN_MAX result-free cycles.
module mesh_seq_ctrl
  import mesh_seq_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int DRAIN_MAX = 1023
) (
  input logic CLK,
  input logic RST,
  mesh_seq_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [CNT_W-1:0] rows_r, iss_cnt, res_cnt;
  logic [SHIFT_W-1:0] shift_r;
  logic prop_r, accept, issue, res, res_last, last_iss, wd_hit;
  logic [DIM*ROW_W-1:0] line;
  if (DIM < 1 || DIM > 255 || DRAIN_MAX < 1) $error("mesh_seq_ctrl: unsupported DIM or DRAIN_MAX");
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign issue = bus.in_valid & bus.in_ready;
  assign res = bus.mesh_out_valid & (state == COMPUTE || state == DRAIN);
  assign res_last = res && (res_cnt + CNT_W'(1) == rows_r);
  assign last_iss = issue && (iss_cnt == (state == PRELOAD ? CNT_W'(DIM - 1) : rows_r - CNT_W'(1)));
`ifdef MESH_SEQ_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_MAX + 1);
  logic [DW-1:0] drain_cnt;
  logic err_r;
  assign wd_hit = state == DRAIN && !res && drain_cnt == DW'(DRAIN_MAX - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      drain_cnt <= '0;
      err_r <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN && !res) ? drain_cnt + DW'(1) : '0;
      err_r <= err_r | wd_hit;
    end
  assign bus.err = err_r;
`else
  assign wd_hit = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !accept ? IDLE : bus.cmd_preload ? PRELOAD : (bus.cmd_rows != '0) ? COMPUTE : DONE;
      PRELOAD: state_n = !last_iss ? PRELOAD : (rows_r != '0) ? COMPUTE : DONE;
      COMPUTE: state_n = last_iss ? DRAIN : COMPUTE;
      DRAIN: state_n = (res_last || wd_hit) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      rows_r <= '0;
      shift_r <= '0;
      prop_r <= 1'b0;
      iss_cnt <= '0;
      res_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rows_r <= bus.cmd_rows;
        shift_r <= bus.cmd_shift;
        prop_r <= prop_r ^ bus.cmd_preload;
      end
      iss_cnt <= (accept || last_iss) ? '0 : (issue && iss_cnt != '1) ? iss_cnt + CNT_W'(1) : iss_cnt;
      res_cnt <= accept ? '0 : (res && res_cnt != '1) ? res_cnt + CNT_W'(1) : res_cnt;
    end
  assign bus.cmd_ready = state == IDLE;
  assign bus.in_ready = state == PRELOAD || state == COMPUTE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.res_valid = res;
  assign bus.res_last = res_last;
  // bubbles carry all-zero control so idle rows never propagate or shift
  mesh_skew_line #(.DIM(DIM), .W(ROW_W)) u_skew (
    .clk(CLK),
    .rst(RST),
    .word({issue, issue & prop_r, issue ? shift_r : SHIFT_W'(0)}),
    .line(line)
  );
  for (genvar i = 0; i < DIM; i++) begin : g_row
    assign bus.mesh_valid[i] = line[i*ROW_W + ROW_W - 1];
    assign bus.mesh_propagate[i] = line[i*ROW_W + SHIFT_W];
    assign bus.mesh_shift[i*SHIFT_W +: SHIFT_W] = line[i*ROW_W +: SHIFT_W];
  end
endmodule

// File: doc/mesh_seq_ctrl.md
MESH_SEQ_CTRL -- requirements
Module: mesh_seq_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning mesh rows/columns.
REQ-002 SHALL have parameter DRAIN_MAX, default 1023, meaning watchdog limit in cycles; used only with MESH_SEQ_TIMEOUT_EN.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid in 1 / cmd_ready out 1 for the tile command handshake.
REQ-006 SHALL have ports cmd_rows in 8 (A rows to stream), cmd_preload in 1 (run PRELOAD phase) and cmd_shift in 5 (output shift).
REQ-007 SHALL have ports in_valid in 1 / in_ready out 1 for the row-data handshake with the operand buffer.
REQ-008 SHALL have ports mesh_valid out DIM, mesh_propagate out DIM and mesh_shift out 5*DIM, each driving row i of the mesh.
REQ-009 SHALL have ports mesh_out_valid in 1 (mesh column-0 output valid), res_valid out 1 and res_last out 1.
REQ-010 SHALL have ports busy out 1, done out 1 (one-cycle pulse) and err out 1 (sticky).

Function
REQ-011 SHALL implement FSM states IDLE, PRELOAD, COMPUTE, DRAIN and DONE.
REQ-012 SHALL drive cmd_ready=1 only in IDLE, and SHALL latch rows, preload and shift on cmd_valid&cmd_ready.
REQ-013 On accept, next state SHALL be: PRELOAD if preload=1; else COMPUTE if rows>0; else DONE.
REQ-014 SHALL drive in_ready=1 only in PRELOAD and COMPUTE; an issue occurs on in_valid&in_ready.
REQ-015 PRELOAD SHALL exit after exactly DIM issues, to COMPUTE if rows>0, else to DONE.
REQ-016 COMPUTE SHALL exit to DRAIN after exactly rows issues.
REQ-017 Each issue SHALL set row-0 valid=1 for one cycle; a cycle without an issue SHALL insert a bubble (valid=0).
REQ-018 mesh_valid[i], mesh_propagate[i] and mesh_shift[i] SHALL equal the row-0 values delayed i cycles (diagonal skew), giving row-0 latency 1 cycle after issue.
REQ-019 Internal bit prop_r SHALL toggle on every accepted command with preload=1; every issue of that command SHALL carry prop_r.
REQ-020 SHALL count mesh_out_valid pulses in COMPUTE and DRAIN, and SHALL echo each pulse as res_valid in the same cycle.
REQ-021 res_last SHALL be asserted with the pulse that equals rows; DRAIN SHALL exit to DONE on that pulse.
REQ-022 A result pulse that coincides with the final COMPUTE issue SHALL be counted.
REQ-023 mesh_out_valid SHALL be ignored in IDLE, PRELOAD and DONE.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Issue and result counters SHALL be 8 bits wide and SHALL NOT wrap within a command.

Reset
REQ-027 RST SHALL asynchronously force IDLE, clear all counters, skew registers and prop_r, and drive cmd_ready=1 with all other outputs 0.
REQ-028 RST asserted mid-operation SHALL abandon the tile; the mesh_valid skew SHALL be all-zero on the first cycle after release.

Configuration
REQ-029 With MESH_SEQ_TIMEOUT_EN defined, a DRAIN counter SHALL reset on each result pulse; reaching DRAIN_MAX SHALL set err (cleared only by RST) and go to DONE.
REQ-030 Without MESH_SEQ_TIMEOUT_EN, there SHALL be no watchdog, err SHALL be tied 0, and DRAIN SHALL wait indefinitely.

Structure
REQ-031 Package mesh_seq_pkg SHALL hold the DIM default, the state enum, SHIFT_W=5 and CNT_W=8.
REQ-032 Sub-module mesh_skew_line (per-row delay chain of width DIM*(2+SHIFT_W)) SHALL implement REQ-018.

Verification
REQ-033 Bench SHALL cover: preload=1, rows=8, in_valid=1 continuously -> 8 PRELOAD plus 8 COMPUTE issues; mesh_valid[7] first high 8 cycles after the first issue; done after the 8th result.
REQ-034 Bench SHALL cover: rows=4, in_valid low on the 2nd cycle -> one bubble in mesh_valid[0] that reappears at mesh_valid[3] 3 cycles later.
REQ-035 Bench SHALL cover: two consecutive preload=1 commands -> propagate 1 on the first tile and 0 on the second; preload=0 command -> propagate unchanged.
REQ-036 Bench SHALL cover: preload=0, rows=0 -> done pulses 1 cycle after accept with no issues.
REQ-037 Bench SHALL cover: RST pulse in COMPUTE after 3 issues -> cmd_ready=1 and mesh_valid=0 immediately.
REQ-038 Bench SHALL cover, with MESH_SEQ_TIMEOUT_EN and DRAIN_MAX=16: no results -> err=1 and done after 16 DRAIN cycles.
